bias_add_scheduler: RTL and testbench

Sequences the per-channel bias addition for one convolution layer's output stream (e.g. fire2 squeeze, 16 channels). Accumulator results arrive channel-interleaved, channel 0 through NUM_CH-1 for each pixel. The block tracks channel and pixel position, selects the matching entry from the layer's bias ROM array, adds it, and forwards the result downstream under valid/ready backpressure. It sits between the MAC accumulator bank and the activation/writeback stage, and it signals frame completion to the layer controller.

---
 rtl/bias_sched_pkg.sv | 17 +
 rtl/bias_add_sat.sv | 30 +++
 rtl/bias_add_scheduler.sv | 118 +++++++++++
 tb/tb_bias_add_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bias_sched_pkg.sv
// Shared types and constants for the bias-add scheduler.
package bias_sched_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    // Index width for a counter over n entries; never narrower than one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bias_add_sat.sv
// Combinational signed adder; saturating when BIAS_SAT_EN is defined, wrapping otherwise.
module bias_add_sat
    import bias_sched_pkg::*;
#(
    parameter int unsigned DataW = DATA_W
) (
    input  logic [DataW-1:0] a_i,
    input  logic [DataW-1:0] b_i,
    output logic [DataW-1:0] sum_o
);

`ifdef BIAS_SAT_EN
    logic [DataW:0] sum_ext;

    always_comb begin
        sum_ext = {a_i[DataW-1], a_i} + {b_i[DataW-1], b_i};
        // Top two bits disagree only when the true sum left the DataW range.
        if (sum_ext[DataW] != sum_ext[DataW-1]) begin
            sum_o = sum_ext[DataW] ? {1'b1, {(DataW-1){1'b0}}} : {1'b0, {(DataW-1){1'b1}}};
        end else begin
            sum_o = sum_ext[DataW-1:0];
        end
    end
`else
    always_comb begin
        sum_o = a_i + b_i;
    end
`endif

endmodule

// File: rtl/bias_add_scheduler.sv
// Per-channel bias addition over one frame with valid/ready flow control.
// Optional saturation is selected by the BIAS_SAT_EN macro (see bias_add_sat).
module bias_add_scheduler
    import bias_sched_pkg::*;
#(
    parameter int unsigned NumCh  = 16,
    parameter int unsigned NumPix = 3025,
    parameter int unsigned DataW  = DATA_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    output logic                          busy_o,
    input  logic [NumCh-1:0][DataW-1:0]   bias_mem_i,
    input  logic [DataW-1:0]              acc_data_i,
    input  logic                          acc_valid_i,
    output logic                          acc_ready_o,
    output logic [DataW-1:0]              out_data_o,
    output logic [ch_w(NumCh)-1:0]        out_ch_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          done_o
);

    localparam int unsigned ChW  = ch_w(NumCh);
    localparam int unsigned PixW = ch_w(NumPix);
    localparam logic [ChW-1:0]  LastCh  = ChW'(NumCh - 1);
    localparam logic [PixW-1:0] LastPix = PixW'(NumPix - 1);

    state_e            state_q;
    logic [ChW-1:0]    ch_cnt_q;
    logic [PixW-1:0]   pix_cnt_q;
    logic [DataW-1:0]  out_data_q;
    logic [ChW-1:0]    out_ch_q;
    logic              out_valid_q;
    logic              done_q;

    logic [DataW-1:0]  sum;
    logic              accept;
    logic              out_hs;
    logic              last_word;

    bias_add_sat #(
        .DataW (DataW)
    ) u_add (
        .a_i   (acc_data_i),
        .b_i   (bias_mem_i[ch_cnt_q]),
        .sum_o (sum)
    );

    always_comb begin
        acc_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
        accept      = acc_valid_i && acc_ready_o;
        out_hs      = out_valid_q && out_ready_i;
        last_word   = (ch_cnt_q == LastCh) && (pix_cnt_q == LastPix);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StRun;
                        ch_cnt_q  <= '0;
                        pix_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (ch_cnt_q == LastCh) begin
                            ch_cnt_q  <= '0;
                            pix_cnt_q <= pix_cnt_q + PixW'(1);
                        end else begin
                            ch_cnt_q <= ch_cnt_q + ChW'(1);
                        end
                        if (last_word) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_hs) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A simultaneous accept refills the register, so valid stays high.
            if (accept) begin
                out_data_q  <= sum;
                out_ch_q    <= ch_cnt_q;
                out_valid_q <= 1'b1;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        busy_o      = (state_q != StIdle);
        out_data_o  = out_data_q;
        out_ch_o    = out_ch_q;
        out_valid_o = out_valid_q;
        done_o      = done_q;
    end

endmodule

// File: tb/tb_bias_add_scheduler.sv
// Directed bench for bias_add_scheduler: streaming, backpressure, overflow, restart, reset.
module tb_bias_add_scheduler;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                busy;
    logic [15:0][31:0]   bias_mem;
    logic [31:0]         acc_data;
    logic                acc_valid;
    logic                acc_ready;
    logic [31:0]         out_data;
    logic [3:0]          out_ch;
    logic                out_valid;
    logic                out_ready;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;

    bias_add_scheduler #(
        .NumCh  (16),
        .NumPix (2),
        .DataW  (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .busy_o      (busy),
        .bias_mem_i  (bias_mem),
        .acc_data_i  (acc_data),
        .acc_valid_i (acc_valid),
        .acc_ready_o (acc_ready),
        .out_data_o  (out_data),
        .out_ch_o    (out_ch),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'(signed'(a)) + longint'(signed'(b));
`ifdef BIAS_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    // One frame of 32 words; negative arguments disable the optional event.
    task automatic run_frame(input int stall_at, input int ovf_word, input int restart_word,
                             input int rst_word);
        int          acc_n = 0;
        int          out_n = 0;
        int          cyc   = 0;
        bit          restarted = 0;
        bit          held_valid = 0;
        logic [31:0] held_data;
        logic [3:0]  held_ch;
        logic [31:0] word_val [32];
        logic [3:0]  ch;
        bit          acc_hs;
        bit          o_hs;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", {31'b0, busy}, 32'd1);

        while (out_n < 32 && cyc < 500) begin
            acc_data  = (acc_n == ovf_word) ? 32'h7FFF_FF00 : 32'd1000;
            acc_valid = (acc_n < 32);
            out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
            start     = 1'b0;
            if (acc_n == restart_word && !restarted) begin
                start     = 1'b1;
                restarted = 1;
            end
            #1;
            if (rst_word >= 0 && acc_n == rst_word) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", {31'b0, busy}, 32'd0);
                check_eq("rst_acc_ready", {31'b0, acc_ready}, 32'd0);
                check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
                check_eq("rst_out_data", out_data, 32'd0);
                check_eq("rst_out_ch", {28'b0, out_ch}, 32'd0);
                check_eq("rst_done", {31'b0, done}, 32'd0);
                @(negedge clk);
                rst_n     = 1'b1;
                acc_valid = 1'b0;
                out_ready = 1'b1;
                return;
            end
            if (!out_ready) begin
                check_eq("stall_acc_ready", {31'b0, acc_ready}, 32'd0);
                check_eq("stall_out_valid", {31'b0, out_valid}, 32'd1);
                if (held_valid) begin
                    check_eq("stall_data_hold", out_data, held_data);
                    check_eq("stall_ch_hold", {28'b0, out_ch}, {28'b0, held_ch});
                end
                held_data  = out_data;
                held_ch    = out_ch;
                held_valid = 1;
            end
            acc_hs = acc_valid && acc_ready;
            o_hs   = out_valid && out_ready;
            if (o_hs) begin
                ch = 4'(out_n % 16);
                check_eq("out_ch", {28'b0, out_ch}, {28'b0, ch});
                check_eq("out_data", out_data, exp_sum(word_val[out_n], bias_mem[ch]));
                if (out_n == ovf_word) begin
`ifdef BIAS_SAT_EN
                    check_eq("ovf_sat", out_data, 32'h7FFF_FFFF);
`else
                    check_eq("ovf_wrap", out_data, 32'h8000_0753);
`endif
                end else if (ch == 4'd1) begin
                    check_eq("ch1_sum", out_data, 32'd1845);
                end else if (ch == 4'd3) begin
                    check_eq("ch3_sum", out_data, 32'd520);
                end
                out_n++;
            end
            if (acc_hs) begin
                word_val[acc_n] = acc_data;
                acc_n++;
            end
            cyc++;
            @(negedge clk);
        end
        acc_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("out_count", out_n, 32'd32);
        check_eq("done_pulse", {31'b0, done}, 32'd1);
        check_eq("done_busy_low", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check_eq("done_single", {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        acc_data  = '0;
        acc_valid = 1'b0;
        out_ready = 1'b1;
        bias_mem  = '0;
        bias_mem[1]  = 32'd845;
        bias_mem[3]  = 32'hFFFF_FE20;
        bias_mem[13] = 32'd2131;
        #3;
        check_eq("reset_busy", {31'b0, busy}, 32'd0);
        check_eq("reset_acc_ready", {31'b0, acc_ready}, 32'd0);
        check_eq("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("reset_out_data", out_data, 32'd0);
        check_eq("reset_out_ch", {28'b0, out_ch}, 32'd0);
        check_eq("reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(-100, -1, -1, -1);
        run_frame(8, 13, 10, -1);
        run_frame(-100, -1, -1, 7);
        run_frame(-100, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
